// File: rtl/bcd_gray_if.sv
// bcd_gray_if: nibble-in / Gray-out bus for bcd_gray; err_cnt present only with BCD_GRAY_ERR_CNT_EN
interface bcd_gray_if #(parameter int ERR_CNT_W = 8);
  logic in_valid;
  logic a, x, y, z;
  logic e, f, g, h;
  logic out_valid;
  logic bcd_err;
`ifdef BCD_GRAY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
  modport master (output in_valid, a, x, y, z, input e, f, g, h, out_valid, bcd_err, err_cnt);
  modport slave (input in_valid, a, x, y, z, output e, f, g, h, out_valid, bcd_err, err_cnt);
`else
  modport master (output in_valid, a, x, y, z, input e, f, g, h, out_valid, bcd_err);
  modport slave (input in_valid, a, x, y, z, output e, f, g, h, out_valid, bcd_err);
`endif
endinterface

// File: rtl/bcd_gray.sv
// bcd_gray: registered 4-bit binary-to-Gray converter with BCD range flag; BCD_GRAY_ERR_CNT_EN adds a saturating error counter
module bcd_gray (
  input logic clk,
  input logic rst_n,
  bcd_gray_if.slave bus
);
  logic [3:0] code;
  logic err, vld, in_err;
  assign in_err = bus.a & (bus.x | bus.y);
  // capture converted code and range flag on valid input, hold otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      code <= '0;
      err <= 1'b0;
      vld <= 1'b0;
    end else begin
      vld <= bus.in_valid;
      if (bus.in_valid) begin
        code <= {bus.a, bus.a ^ bus.x, bus.x ^ bus.y, bus.y ^ bus.z};
        err <= in_err;
      end
    end
  assign {bus.e, bus.f, bus.g, bus.h} = code;
  assign bus.bcd_err = err;
  assign bus.out_valid = vld;
`ifdef BCD_GRAY_ERR_CNT_EN
  logic [$bits(bus.err_cnt)-1:0] cnt;
  // count accepted out-of-range nibbles, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (bus.in_valid && in_err && !(&cnt)) cnt <= cnt + 1'b1;
  assign bus.err_cnt = cnt;
`endif
endmodule

// File: tb/tb_bcd_gray.sv
// tb_bcd_gray: table vectors, corner sequences and random run against an arithmetic reference
module tb_bcd_gray;
`ifdef BCD_GRAY_ERR_CNT_EN
  localparam int W = 2;
`else
  localparam int W = 8;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int mcnt = 0;
  bcd_gray_if #(.ERR_CNT_W(W)) bus();
  bcd_gray dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {logic [3:0] n; logic [3:0] g; logic err;} vec_t;
  vec_t tbl[13];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(string name, logic [3:0] g, logic err, logic ov);
    chk({name, " efgh"}, int'({bus.e, bus.f, bus.g, bus.h}), int'(g));
    chk({name, " bcd_err"}, int'(bus.bcd_err), int'(err));
    chk({name, " out_valid"}, int'(bus.out_valid), int'(ov));
  endtask

  task automatic drive(logic v, logic [3:0] n);
    bus.in_valid = v;
    {bus.a, bus.x, bus.y, bus.z} = n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_model(logic v, logic [3:0] n);
    if (v && n > 9 && mcnt < (1 << W) - 1) mcnt++;
  endtask

  initial begin
    logic [3:0] mg, n;
    logic me, v;
    tbl[0] = '{4'b1000, 4'b1100, 1'b0};
    tbl[1] = '{4'b1110, 4'b1001, 1'b1};
    tbl[2] = '{4'b1101, 4'b1011, 1'b1};
    tbl[3] = '{4'd0, 4'b0000, 1'b0};
    tbl[4] = '{4'd1, 4'b0001, 1'b0};
    tbl[5] = '{4'd2, 4'b0011, 1'b0};
    tbl[6] = '{4'd3, 4'b0010, 1'b0};
    tbl[7] = '{4'd4, 4'b0110, 1'b0};
    tbl[8] = '{4'd5, 4'b0111, 1'b0};
    tbl[9] = '{4'd6, 4'b0101, 1'b0};
    tbl[10] = '{4'd7, 4'b0100, 1'b0};
    tbl[11] = '{4'd8, 4'b1100, 1'b0};
    tbl[12] = '{4'd9, 4'b1101, 1'b0};

    drive(1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("reset hold", 4'b0000, 1'b0, 1'b0);
`ifdef BCD_GRAY_ERR_CNT_EN
      chk("reset err_cnt", int'(bus.err_cnt), 0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("post release", 4'b0000, 1'b0, 1'b0);
    tick();
    chk_out("first after reset", 4'b1000, 1'b1, 1'b1);

    for (int i = 0; i < 13; i++) begin
      drive(1'b1, tbl[i].n);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].err, 1'b1);
    end

    drive(1'b1, 4'b0101);
    tick();
    chk_out("hold load", 4'b0111, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'($urandom));
      tick();
      chk_out("hold idle", 4'b0111, 1'b0, 1'b0);
    end

    drive(1'b1, 4'b1011);
    tick();
    chk_out("async pre", 4'b1110, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async clear", 4'b0000, 1'b0, 1'b0);
    #3;
    chk_out("async held", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mcnt = 0;
    drive(1'b1, 4'b0010);
    tick();
    chk_out("restart", 4'b0011, 1'b0, 1'b1);

`ifdef BCD_GRAY_ERR_CNT_EN
    chk("cnt start", int'(bus.err_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b1111);
      tick();
      count_model(1'b1, 4'b1111);
      chk($sformatf("err_cnt step%0d", i), int'(bus.err_cnt), (i < 3) ? i + 1 : 3);
    end
    drive(1'b1, 4'b0011);
    tick();
    chk("err_cnt valid nibble", int'(bus.err_cnt), 3);
`endif

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mcnt = 0;
    mg = 4'd0;
    me = 1'b0;
    for (int i = 0; i < 300; i++) begin
      v = 1'($urandom);
      n = 4'($urandom);
      drive(v, n);
      tick();
      if (v) begin
        mg = n ^ (n >> 1);
        me = n > 9;
      end
      count_model(v, n);
      chk_out("random", mg, me, v);
`ifdef BCD_GRAY_ERR_CNT_EN
      chk("random err_cnt", int'(bus.err_cnt), mcnt);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
